// File: rtl/fetch_stage.sv
// Instruction fetch: owns the PC, drives ROM address, fills the IF/ID register.
// Latency: ROM word at PC=A appears on Instruction one edge later; 1 instr/cycle.
// Backpressure: Stall freezes PC/IF/ID/count; a taken branch overrides Stall and halt.
module fetch_stage #(
  parameter logic [15:0] RESET_PC  = 16'h0000,
  parameter logic [15:0] NOP_WORD  = 16'h0000,
  parameter logic [15:0] HALT_WORD = 16'hFFFF
) (
  input  logic        clk,
  input  logic        Reset,
  input  logic        Stall,
  input  logic        BranchTK,
  input  logic [15:0] Broffset,
  input  logic [15:0] ImData,
  output logic [15:0] ImAddr,
  output logic [15:0] Instruction,
  output logic [15:0] PCD,
  output logic        Valid,
  output logic        Flush,
  output logic        Halted,
  output logic [15:0] FetchCount
);

  // Fetch FSM: FETCH runs normally, HALT parks the PC on the halt word.
  localparam logic [0:0] ST_FETCH = 1'b0;
  localparam logic [0:0] ST_HALT  = 1'b1;

  logic [0:0]  state;
  logic [0:0]  state_nxt;
  logic [15:0] pc;
  logic [15:0] pc_nxt;
  logic        fetch_go;
  logic        is_halt_word;

  logic [15:0] instr_q;
  logic [15:0] pcd_q;
  logic        valid_q;
  logic [15:0] count_q;

  // A normal fetch happens only when nothing of higher priority claims the edge.
  always_comb begin
    fetch_go     = !BranchTK && !Stall && (state == ST_FETCH);
    is_halt_word = (ImData == HALT_WORD);
  end

  // Next FSM state: a branch always clears halt (also cancels a wrong-path halt).
  always_comb begin
    state_nxt = state;
    if (BranchTK) begin
      state_nxt = ST_FETCH;
    end else if (fetch_go && is_halt_word) begin
      state_nxt = ST_HALT;
    end
  end

  // Next PC: redirect on branch, otherwise increment on every non-halt fetch.
  always_comb begin
    pc_nxt = pc;
    if (BranchTK) begin
      pc_nxt = Broffset;
    end else if (fetch_go && !is_halt_word) begin
      pc_nxt = pc + 16'd1;
    end
  end

  // PC and FSM state registers.
  always_ff @(posedge clk) begin
    if (Reset) begin
      pc    <= RESET_PC;
      state <= ST_FETCH;
    end else begin
      pc    <= pc_nxt;
      state <= state_nxt;
    end
  end

  // IF/ID pipeline register: bubble on branch or halt, hold on stall.
  always_ff @(posedge clk) begin
    if (Reset) begin
      instr_q <= NOP_WORD;
      pcd_q   <= 16'h0000;
      valid_q <= 1'b0;
    end else if (BranchTK) begin
      instr_q <= NOP_WORD;
      pcd_q   <= 16'h0000;
      valid_q <= 1'b0;
    end else if (Stall) begin
      instr_q <= instr_q;
      pcd_q   <= pcd_q;
      valid_q <= valid_q;
    end else if (state == ST_HALT) begin
      instr_q <= NOP_WORD;
      pcd_q   <= 16'h0000;
      valid_q <= 1'b0;
    end else begin
      instr_q <= ImData;
      pcd_q   <= pc;
      valid_q <= 1'b1;
    end
  end

  // Count every word accepted into IF/ID, including the halt word itself.
  always_ff @(posedge clk) begin
    if (Reset) begin
      count_q <= 16'h0000;
    end else if (fetch_go) begin
      count_q <= count_q + 16'd1;
    end
  end

  // Outputs: address and flush are combinational, the rest come from registers.
  always_comb begin
    ImAddr      = pc;
    Flush       = BranchTK;
    Instruction = instr_q;
    PCD         = pcd_q;
    Valid       = valid_q;
    Halted      = (state == ST_HALT);
    FetchCount  = count_q;
  end

endmodule

// File: tb/tb_fetch_stage.sv
// Bench for fetch_stage: directed scenarios plus randomized traffic
// compared against a rule-level model of the fetch stage.
module tb_fetch_stage;

  localparam logic [15:0] NOP  = 16'h0000;
  localparam logic [15:0] HALT = 16'hFFFF;

  logic        clk;
  logic        Reset;
  logic        Stall;
  logic        BranchTK;
  logic [15:0] Broffset;
  logic [15:0] ImData;
  logic [15:0] ImAddr;
  logic [15:0] Instruction;
  logic [15:0] PCD;
  logic        Valid;
  logic        Flush;
  logic        Halted;
  logic [15:0] FetchCount;

  logic [15:0] rom [0:65535];

  int checks;
  int failures;

  // model state
  logic [15:0] e_pc;
  logic [15:0] e_instr;
  logic [15:0] e_pcd;
  logic        e_valid;
  logic        e_halt;
  logic [15:0] e_cnt;

  fetch_stage dut (
    .clk(clk), .Reset(Reset), .Stall(Stall), .BranchTK(BranchTK),
    .Broffset(Broffset), .ImData(ImData), .ImAddr(ImAddr),
    .Instruction(Instruction), .PCD(PCD), .Valid(Valid), .Flush(Flush),
    .Halted(Halted), .FetchCount(FetchCount)
  );

  assign ImData = rom[ImAddr];

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Apply the stage's per-edge rules to the model, then advance one edge.
  task automatic tick();
    logic [15:0] w;
    if (Reset) begin
      e_pc = 16'h0000; e_instr = NOP; e_pcd = 16'h0000;
      e_valid = 1'b0; e_halt = 1'b0; e_cnt = 16'h0000;
    end else if (BranchTK) begin
      e_pc = Broffset; e_instr = NOP; e_pcd = 16'h0000;
      e_valid = 1'b0; e_halt = 1'b0;
    end else if (Stall) begin
      // everything holds
    end else if (e_halt) begin
      e_instr = NOP; e_pcd = 16'h0000; e_valid = 1'b0;
    end else begin
      w = rom[e_pc];
      e_instr = w; e_pcd = e_pc; e_valid = 1'b1; e_cnt = e_cnt + 16'd1;
      if (w == HALT) e_halt = 1'b1;
      else e_pc = e_pc + 16'd1;
    end
    @(posedge clk);
    #1;
  endtask

  task automatic idle_inputs();
    Reset = 1'b0; Stall = 1'b0; BranchTK = 1'b0; Broffset = 16'h0000;
  endtask

  task automatic do_reset();
    idle_inputs();
    Reset = 1'b1;
    tick();
    Reset = 1'b0;
  endtask

  task automatic test_reset();
    do_reset();
    checks++; if (ImAddr !== 16'h0000) begin failures++; $display("FAIL reset_imaddr got=%h exp=0000", ImAddr); end
    checks++; if (Instruction !== NOP) begin failures++; $display("FAIL reset_instr got=%h exp=%h", Instruction, NOP); end
    checks++; if (PCD !== 16'h0000) begin failures++; $display("FAIL reset_pcd got=%h exp=0000", PCD); end
    checks++; if (Valid !== 1'b0) begin failures++; $display("FAIL reset_valid got=%b exp=0", Valid); end
    checks++; if (Halted !== 1'b0) begin failures++; $display("FAIL reset_halted got=%b exp=0", Halted); end
    checks++; if (FetchCount !== 16'h0000) begin failures++; $display("FAIL reset_count got=%h exp=0000", FetchCount); end
    checks++; if (Flush !== 1'b0) begin failures++; $display("FAIL reset_flush got=%b exp=0", Flush); end
  endtask

  task automatic test_sequential();
    logic [15:0] words [4];
    words[0] = 16'h1111; words[1] = 16'h2222; words[2] = 16'h3333; words[3] = 16'h4444;
    for (int i = 0; i < 4; i++) rom[i] = words[i];
    do_reset();
    for (int i = 0; i < 4; i++) begin
      tick();
      checks++; if (Instruction !== words[i] || PCD !== 16'(i) || Valid !== 1'b1) begin
        failures++; $display("FAIL seq_fetch%0d got=%h/%h/%b exp=%h/%h/1", i, Instruction, PCD, Valid, words[i], 16'(i));
      end
    end
    checks++; if (FetchCount !== 16'd4) begin failures++; $display("FAIL seq_count got=%0d exp=4", FetchCount); end
  endtask

  task automatic test_stall();
    do_reset();
    tick(); tick();
    Stall = 1'b1;
    for (int i = 0; i < 3; i++) begin
      tick();
      checks++; if (ImAddr !== 16'd2 || Instruction !== 16'h2222 || PCD !== 16'd1 || FetchCount !== 16'd2) begin
        failures++; $display("FAIL stall_hold%0d got=%h/%h/%h/%0d exp=0002/2222/0001/2", i, ImAddr, Instruction, PCD, FetchCount);
      end
    end
    Stall = 1'b0;
    tick();
    checks++; if (PCD !== 16'd2 || Instruction !== 16'h3333 || Valid !== 1'b1) begin
      failures++; $display("FAIL stall_resume got=%h/%h/%b exp=0002/3333/1", PCD, Instruction, Valid);
    end
  endtask

  task automatic test_branch();
    do_reset();
    for (int i = 0; i < 5; i++) tick();
    BranchTK = 1'b1; Broffset = 16'h0040;
    #1;
    checks++; if (Flush !== 1'b1) begin failures++; $display("FAIL branch_flush got=%b exp=1", Flush); end
    checks++; if (ImAddr !== 16'd5) begin failures++; $display("FAIL branch_pc5 got=%h exp=0005", ImAddr); end
    tick();
    BranchTK = 1'b0;
    checks++; if (Valid !== 1'b0 || Instruction !== NOP || ImAddr !== 16'h0040) begin
      failures++; $display("FAIL branch_bubble got=%b/%h/%h exp=0/%h/0040", Valid, Instruction, ImAddr, NOP);
    end
    checks++; if (FetchCount !== 16'd5) begin failures++; $display("FAIL branch_count got=%0d exp=5", FetchCount); end
    tick();
    checks++; if (PCD !== 16'h0040 || Valid !== 1'b1 || Instruction !== rom[16'h0040]) begin
      failures++; $display("FAIL branch_target got=%h/%b/%h exp=0040/1/%h", PCD, Valid, Instruction, rom[16'h0040]);
    end
  endtask

  task automatic test_halt();
    rom[7] = HALT;
    do_reset();
    for (int i = 0; i < 8; i++) tick();
    checks++; if (Halted !== 1'b1 || ImAddr !== 16'd7 || Instruction !== HALT || Valid !== 1'b1 || FetchCount !== 16'd8) begin
      failures++; $display("FAIL halt_enter got=%b/%h/%h/%b/%0d exp=1/0007/ffff/1/8", Halted, ImAddr, Instruction, Valid, FetchCount);
    end
    for (int i = 0; i < 3; i++) begin
      tick();
      checks++; if (Valid !== 1'b0 || FetchCount !== 16'd8 || ImAddr !== 16'd7 || Halted !== 1'b1) begin
        failures++; $display("FAIL halt_hold%0d got=%b/%0d/%h/%b exp=0/8/0007/1", i, Valid, FetchCount, ImAddr, Halted);
      end
    end
    BranchTK = 1'b1; Broffset = 16'h0010;
    tick();
    BranchTK = 1'b0;
    checks++; if (Halted !== 1'b0 || ImAddr !== 16'h0010) begin
      failures++; $display("FAIL halt_exit got=%b/%h exp=0/0010", Halted, ImAddr);
    end
    tick();
    checks++; if (PCD !== 16'h0010 || Valid !== 1'b1) begin
      failures++; $display("FAIL halt_resume got=%h/%b exp=0010/1", PCD, Valid);
    end
    rom[7] = 16'h0007;
  endtask

  task automatic test_wrap();
    rom[16'hFFFF] = 16'h1234;
    do_reset();
    BranchTK = 1'b1; Broffset = 16'hFFFF;
    tick();
    BranchTK = 1'b0;
    tick();
    checks++; if (ImAddr !== 16'h0000 || PCD !== 16'hFFFF || Instruction !== 16'h1234) begin
      failures++; $display("FAIL wrap got=%h/%h/%h exp=0000/ffff/1234", ImAddr, PCD, Instruction);
    end
  endtask

  task automatic test_back_to_back();
    do_reset();
    tick(); tick(); tick();
    Stall = 1'b1; BranchTK = 1'b1; Broffset = 16'h0123;
    tick();
    BranchTK = 1'b0;
    checks++; if (ImAddr !== 16'h0123 || Valid !== 1'b0 || Instruction !== NOP) begin
      failures++; $display("FAIL stall_branch got=%h/%b/%h exp=0123/0/%h", ImAddr, Valid, Instruction, NOP);
    end
    Stall = 1'b0;
    tick(); tick();
    Stall = 1'b1; Reset = 1'b1;
    tick();
    Reset = 1'b0; Stall = 1'b0;
    checks++; if (ImAddr !== 16'h0000 || Instruction !== NOP || PCD !== 16'h0000 || Valid !== 1'b0 ||
                  Halted !== 1'b0 || FetchCount !== 16'h0000) begin
      failures++; $display("FAIL reset_in_stall got=%h/%h/%h/%b/%b/%0d exp=0000/%h/0000/0/0/0",
                           ImAddr, Instruction, PCD, Valid, Halted, FetchCount, NOP);
    end
  endtask

  task automatic test_random();
    int errs;
    errs = 0;
    for (int a = 0; a < 64; a++) rom[a] = ($urandom_range(0, 11) == 0) ? HALT : 16'($urandom_range(0, 16'hFFFE));
    do_reset();
    for (int c = 0; c < 400; c++) begin
      Reset    = ($urandom_range(0, 49) == 0);
      Stall    = ($urandom_range(0, 3) == 0);
      BranchTK = ($urandom_range(0, 9) == 0);
      Broffset = 16'($urandom_range(0, 63));
      #1;
      checks++; if (Flush !== BranchTK || ImAddr !== e_pc) begin
        failures++; errs++;
        if (errs < 10) $display("FAIL rand_comb c=%0d got=%b/%h exp=%b/%h", c, Flush, ImAddr, BranchTK, e_pc);
      end
      tick();
      checks++; if (ImAddr !== e_pc || Instruction !== e_instr || PCD !== e_pcd || Valid !== e_valid ||
                    Halted !== e_halt || FetchCount !== e_cnt) begin
        failures++; errs++;
        if (errs < 10) $display("FAIL rand_state c=%0d got=%h/%h/%h/%b/%b/%h exp=%h/%h/%h/%b/%b/%h", c,
                                ImAddr, Instruction, PCD, Valid, Halted, FetchCount,
                                e_pc, e_instr, e_pcd, e_valid, e_halt, e_cnt);
      end
    end
    idle_inputs();
  endtask

  initial begin
    checks = 0;
    failures = 0;
    for (int a = 0; a < 65536; a++) rom[a] = {1'b0, 15'(a)};
    idle_inputs();
    Reset = 1'b1;
    test_reset();
    test_sequential();
    test_stall();
    test_branch();
    test_halt();
    test_wrap();
    test_back_to_back();
    test_random();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/fetch_stage.md
# fetch_stage

Instruction-fetch stage of the 16-bit three-stage pipeline (fetch → decode → execute). It owns the program counter, drives the program-ROM address, and latches each fetched word with its PC into the IF/ID pipeline register that feeds decode. It accepts the taken-branch redirect produced by the execute stage, and handles stall, flush and halt. All state changes on the rising edge of `clk`.

## Interface
Parameters:
- `RESET_PC`, default 16'h0000: PC loaded on reset.
- `NOP_WORD`, default 16'h0000: instruction word inserted as a bubble.
- `HALT_WORD`, default 16'hFFFF: instruction word that halts fetch.

Ports:
- `clk`  in  1: the single clock; all state on its rising edge.
- `Reset`  in  1: synchronous, active-high reset, sampled on the rising edge of `clk`.
- `Stall`  in  1: hold PC and IF/ID contents.
- `BranchTK`  in  1: execute stage reports a taken branch this cycle.
- `Broffset`  in  16: absolute branch target from execute.
- `ImData`  in  16: program-ROM read data, combinational from `ImAddr`.
- `ImAddr`  out  16: ROM address; combinational copy of PC.
- `Instruction`  out  16: IF/ID registered instruction.
- `PCD`  out  16: IF/ID registered PC of `Instruction`.
- `Valid`  out  1: IF/ID holds a real instruction (0 = bubble).
- `Flush`  out  1: combinational copy of `BranchTK`; tells decode to squash its ID/EX contents.
- `Halted`  out  1: fetch is stopped on `HALT_WORD`.
- `FetchCount`  out  16: number of instructions accepted into IF/ID.

## Operation
- PC is word-addressed and advances by 1 per accepted fetch.
- 16-bit wrap: 16'hFFFF + 1 = 16'h0000, with no flag.
- Per-edge priority, highest first:
  1. `Reset`: PC=`RESET_PC`, `Instruction`=`NOP_WORD`, `PCD`=0, `Valid`=0, `Halted`=0, `FetchCount`=0.
  2. `BranchTK`: PC=`Broffset`, IF/ID loads a bubble (`Instruction`=`NOP_WORD`, `PCD`=0, `Valid`=0), `Halted`=0.
     - Branch wins over `Stall` and over `Halted`.
     - The wrong-path word currently on `ImData` is discarded and not counted.
  3. `Stall`: PC, IF/ID, `Halted` and `FetchCount` all hold.
  4. `Halted`=1: PC holds, IF/ID loads a bubble, `FetchCount` holds.
  5. Normal fetch: `Instruction`=`ImData`, `PCD`=PC, `Valid`=1, PC=PC+1, `FetchCount`+=1.
     - If `ImData`==`HALT_WORD`, the halt word is still latched as a valid instruction and counted.
     - On the same edge, `Halted`=1 and PC holds at the halt address instead of incrementing.
- State machine:
  - States: FETCH (`Halted`=0) and HALT (`Halted`=1).
  - FETCH→HALT on a normal fetch of `HALT_WORD`.
  - HALT→FETCH only on `BranchTK` or `Reset`.
  - A halt fetched on a wrong path is cancelled by the branch that redirects it.
- `Flush` = `BranchTK` (combinational, no register). `ImAddr` = PC (combinational).

## Timing
- Reset values: `ImAddr`=`RESET_PC`, `Instruction`=`NOP_WORD`, `PCD`=0, `Valid`=0, `Flush`=`BranchTK`, `Halted`=0, `FetchCount`=0.
- Fetch latency: the word at address A appears on `Instruction` one edge after PC=A with no stall.
- Throughput: one instruction per cycle.
- Branch penalty, counting bubbles at IF/ID:
  - Edge of `BranchTK`: IF/ID becomes a bubble and PC=target.
  - Next edge: the target word is latched, `Valid`=1.
  - Decode squashes its own entry via `Flush`, for two bubbles total reaching execute.
- Stall is zero-latency: outputs are unchanged on the edge where `Stall`=1.
- `Reset` asserted mid-stall or mid-halt takes effect on that edge; no other input is honoured.
- `Stall` and `BranchTK` in the same cycle: the branch is taken, the stall is ignored for this block.
- `ImData` is sampled only on edges where a normal fetch occurs.

## Test plan
- Reset, then ROM[0..3] = 16'h1111, 16'h2222, 16'h3333, 16'h4444, no stall:
  - `Instruction`/`PCD` sequence is (1111,0), (2222,1), (3333,2), (4444,3) on successive edges.
  - `Valid`=1 from the first edge after reset.
  - `FetchCount`=4 after 4 edges.
- `Stall`=1 for 3 cycles while PC=2: `ImAddr` stays 2 and `Instruction`/`PCD`/`FetchCount` are frozen; fetch resumes with `PCD`=2 after release.
- `BranchTK`=1, `Broffset`=16'h0040 while PC=5:
  - `Flush`=1 in that cycle.
  - Next edge: `Valid`=0, `Instruction`=`NOP_WORD`, `ImAddr`=16'h0040.
  - Following edge: `PCD`=16'h0040, `Valid`=1.
- ROM[7]=16'hFFFF:
  - After fetching it, `Halted`=1 and `ImAddr` holds 7.
  - `Valid`=0 on every later edge and `FetchCount` stops.
  - Then `BranchTK` with `Broffset`=16'h0010: `Halted`=0, fetch resumes at 16'h0010.
- Start with PC=16'hFFFF by branching to it, then fetch normally: next `ImAddr`=16'h0000 and `PCD`=16'hFFFF.
- `Stall`=1 and `BranchTK`=1 together: branch taken, bubble inserted, PC=`Broffset`. Separately, `Reset` during a stall: all outputs return to their reset values on that edge.
